// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fetch_stage_pkg
// Brief   : Shared types and constants for the IF stage and its IF/ID register.
// Revision: 1.0
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } FetchState_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fetch_stage_if_id_reg
// Brief   : IF/ID pipeline register; clear (bubble/flush) beats enable.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        valid_in,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (clr) begin
      instr_d    = NOP_INSTR;
      pc_d       = 32'd0;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (en) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc_plus4_q;
  assign ValidD   = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : fetch_stage
// Brief   : IF stage: owns PCF, drives the imem request/ready handshake,
//           honours decode stalls and EX redirects.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  FetchState_t state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] skid_q, skid_d;
  logic        started_q, started_d;

  logic [31:0] target;
  logic [31:0] pcf_plus4;
  logic        ifid_load;
  logic        ifid_clr;
  logic        ifid_en;
  logic [31:0] ifid_instr;

  assign target    = word_align(PCTargetE);
  assign pcf_plus4 = pcf_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    pending_d  = pending_q;
    skid_d     = skid_q;
    started_d  = 1'b1;
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;

    // The first cycle out of reset issues nothing, so ready is ignored then.
    if (started_q) begin
      case (state_q)
        FETCH: begin
          if (PCSrcE) begin
            if (imem_ready) begin
              pcf_d = target;
            end else begin
              pending_d = target;
              state_d   = DISCARD;
            end
          end else if (imem_ready) begin
            if (!StallD) begin
              ifid_load = 1'b1;
              pcf_d     = pcf_plus4;
            end else begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          ifid_instr = skid_q;
          if (PCSrcE) begin
            pcf_d   = target;
            state_d = FETCH;
          end else if (!StallD) begin
            ifid_load = 1'b1;
            pcf_d     = pcf_plus4;
            state_d   = FETCH;
          end
        end
        DISCARD: begin
          if (PCSrcE) begin
            pending_d = target;
          end
          if (imem_ready) begin
            pcf_d   = PCSrcE ? target : pending_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Flush outranks stall; an unstalled cycle with nothing to hand over is a bubble.
  assign ifid_en  = !StallD;
  assign ifid_clr = PCSrcE || (!StallD && !ifid_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pcf_q     <= RESET_ADDR;
      pending_q <= RESET_ADDR;
      skid_q    <= NOP_INSTR;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcf_q     <= pcf_d;
      pending_q <= pending_d;
      skid_q    <= skid_d;
      started_q <= started_d;
    end
  end

  assign imem_valid = started_q && (state_q != HOLD);
  assign imem_addr  = pcf_q;

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .en          (ifid_en),
    .clr         (ifid_clr),
    .instr_in    (ifid_instr),
    .pc_in       (pcf_q),
    .pc_plus4_in (pcf_plus4),
    .valid_in    (1'b1),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_fetch_stage
// Brief   : Directed self-checking bench for fetch_stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Memory content: word at address a is a ^ 32'h5A5A_0000.
  assign imem_rdata = imem_addr ^ 32'h5A5A_0000;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .StallD     (StallD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b0;
    StallD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = 32'd0;
    #1;
    chk("rst_valid", {31'd0, imem_valid}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd",   PCD, 32'h0);
    chk("rst_pc4",   PCPlus4D, 32'h0);
    chk("rst_vd",    {31'd0, ValidD}, 32'd0);
    step();
    step();
    reset      = 1'b0;
    imem_ready = 1'b1;
    chk("rel_valid", {31'd0, imem_valid}, 32'd0);

    // Zero-wait memory.
    step();
    chk("zw0_valid", {31'd0, imem_valid}, 32'd1);
    chk("zw0_addr",  imem_addr, 32'h0);
    chk("zw0_vd",    {31'd0, ValidD}, 32'd0);
    step();
    chk("zw1_addr",  imem_addr, 32'h4);
    chk("zw1_instr", InstrD, 32'h5A5A_0000);
    chk("zw1_pcd",   PCD, 32'h0);
    chk("zw1_pc4",   PCPlus4D, 32'h4);
    chk("zw1_vd",    {31'd0, ValidD}, 32'd1);
    step();
    chk("zw2_addr",  imem_addr, 32'h8);
    chk("zw2_pcd",   PCD, 32'h4);
    chk("zw2_pc4",   PCPlus4D, 32'h8);

    // Stall while the response for 0x8 arrives.
    StallD = 1'b1;
    step();
    chk("st0_valid", {31'd0, imem_valid}, 32'd0);
    chk("st0_pcd",   PCD, 32'h4);
    chk("st0_instr", InstrD, 32'h5A5A_0004);
    step();
    chk("st1_valid", {31'd0, imem_valid}, 32'd0);
    chk("st1_pcd",   PCD, 32'h4);
    chk("st1_addr",  imem_addr, 32'h8);
    StallD = 1'b0;
    step();
    chk("st2_instr", InstrD, 32'h5A5A_0008);
    chk("st2_pcd",   PCD, 32'h8);
    chk("st2_addr",  imem_addr, 32'hC);
    chk("st2_valid", {31'd0, imem_valid}, 32'd1);

    // Three-cycle latency on 0xC.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat_addr",  imem_addr, 32'hC);
      chk("lat_vd",    {31'd0, ValidD}, 32'd0);
      chk("lat_instr", InstrD, 32'h0000_0013);
    end
    imem_ready = 1'b1;
    step();
    chk("lat_done_instr", InstrD, 32'h5A5A_000C);
    chk("lat_done_pcd",   PCD, 32'hC);
    chk("lat_done_vd",    {31'd0, ValidD}, 32'd1);
    chk("lat_done_addr",  imem_addr, 32'h10);

    // Redirect (misaligned target) while the fetch of 0x10 waits.
    imem_ready = 1'b0;
    PCSrcE     = 1'b1;
    PCTargetE  = 32'h0000_0101;
    step();
    chk("rd0_addr",  imem_addr, 32'h10);
    chk("rd0_valid", {31'd0, imem_valid}, 32'd1);
    chk("rd0_vd",    {31'd0, ValidD}, 32'd0);
    chk("rd0_instr", InstrD, 32'h0000_0013);
    PCSrcE = 1'b0;
    step();
    chk("rd1_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    step();
    chk("rd2_addr",  imem_addr, 32'h100);
    chk("rd2_vd",    {31'd0, ValidD}, 32'd0);
    chk("rd2_instr", InstrD, 32'h0000_0013);
    step();
    chk("rd3_instr", InstrD, 32'h5A5A_0100);
    chk("rd3_pcd",   PCD, 32'h100);
    chk("rd3_pc4",   PCPlus4D, 32'h104);
    chk("rd3_addr",  imem_addr, 32'h104);

    // Flush and stall together while holding a skid word.
    StallD = 1'b1;
    step();
    chk("hf0_valid", {31'd0, imem_valid}, 32'd0);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0200;
    step();
    chk("hf1_vd",    {31'd0, ValidD}, 32'd0);
    chk("hf1_instr", InstrD, 32'h0000_0013);
    chk("hf1_addr",  imem_addr, 32'h200);
    chk("hf1_valid", {31'd0, imem_valid}, 32'd1);
    PCSrcE = 1'b0;
    StallD = 1'b0;
    step();
    chk("hf2_instr", InstrD, 32'h5A5A_0200);
    chk("hf2_pcd",   PCD, 32'h200);

    // Redirect to the last word; PC+4 wraps to zero.
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFF;
    step();
    chk("wr0_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr0_vd",   {31'd0, ValidD}, 32'd0);
    PCSrcE = 1'b0;
    step();
    chk("wr1_instr", InstrD, 32'hA5A5_FFFC);
    chk("wr1_pcd",   PCD, 32'hFFFF_FFFC);
    chk("wr1_pc4",   PCPlus4D, 32'h0);
    chk("wr1_addr",  imem_addr, 32'h0);

    // Two redirects during one wait: the later target wins.
    imem_ready = 1'b0;
    PCSrcE     = 1'b1;
    PCTargetE  = 32'h0000_0300;
    step();
    PCTargetE = 32'h0000_0400;
    step();
    chk("dd_addr", imem_addr, 32'h0);
    PCSrcE     = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("dd_target", imem_addr, 32'h400);
    imem_ready = 1'b0;
    step();
    chk("dd_wait_addr", imem_addr, 32'h400);

    // Asynchronous reset mid-wait, between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, imem_valid}, 32'd0);
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_instr", InstrD, 32'h0000_0013);
    chk("ar_pcd",   PCD, 32'h0);
    chk("ar_pc4",   PCPlus4D, 32'h0);
    chk("ar_vd",    {31'd0, ValidD}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
